// File: rtl/mem_port_request_queue_if.sv
// Requester, cluster-issue and response signals of one memory-port request queue.
// The slave modport is the queue side; the master modport is the requester/cluster side.
interface mem_port_request_queue_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 2
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wen;
    logic [DATA_W-1:0] req_data;
    logic [TAG_W-1:0]  req_tag;
    logic              mem_valid;
    logic [TAG_W-1:0]  mem_req_tag;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wen;
    logic              freeze_inputs;
    logic              rsp_valid;
    logic [TAG_W-1:0]  rsp_tag;
    logic [TAG_W:0]    outstanding;
    logic              err_sticky;

    modport slave (
        input  req_valid, req_addr, req_wen, req_data, freeze_inputs, rsp_valid, rsp_tag,
        output req_ready, req_tag, mem_valid, mem_req_tag, mem_addr, mem_data, mem_wen,
               outstanding, err_sticky
    );

    modport master (
        output req_valid, req_addr, req_wen, req_data, freeze_inputs, rsp_valid, rsp_tag,
        input  req_ready, req_tag, mem_valid, mem_req_tag, mem_addr, mem_data, mem_wen,
               outstanding, err_sticky
    );
endinterface

// File: rtl/mem_port_request_queue.sv
// Per-port request FIFO with tag assignment and read-tag tracking; optional checks via MEM_PORTQ_ERR_CHECK_EN.
// Latency: accepted request visible on mem_* one cycle later at earliest (empty queue, no freeze).
// Backpressure: req_ready drops when full or next tag busy; head held while freeze_inputs is high.
module mem_port_request_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    mem_port_request_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int NTAGS = 1 << TAG_W;
    localparam logic [PTR_W:0]   PTR_ONE = 1;
    localparam logic [TAG_W-1:0] TAG_ONE = 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              wen;
    } entry_t;

    entry_t           fifo_mem [DEPTH];
    entry_t           head;
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [TAG_W-1:0] next_tag;
    logic [NTAGS-1:0] busy;
    logic [NTAGS-1:0] busy_nxt;
    logic [TAG_W:0]   busy_cnt;
    logic [TAG_W:0]   outstanding_q;
    logic             full;
    logic             empty;
    logic             accept;
    logic             pop;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign accept = bus.req_valid && bus.req_ready;
    assign pop    = !empty && !bus.freeze_inputs;
    assign head   = fifo_mem[rd_ptr[PTR_W-1:0]];

    assign bus.req_ready   = !full && !busy[next_tag];
    assign bus.req_tag     = next_tag;
    assign bus.mem_valid   = !empty;
    assign bus.mem_req_tag = head.tag;
    assign bus.mem_addr    = head.addr;
    assign bus.mem_data    = head.data;
    assign bus.mem_wen     = head.wen;
    assign bus.outstanding = outstanding_q;

    // Set and release never hit the same bit: accept needs busy[next_tag]=0, release needs it 1.
    always_comb begin
        busy_nxt = busy;
        if (accept && !bus.req_wen) busy_nxt[next_tag] = 1'b1;
        if (bus.rsp_valid)          busy_nxt[bus.rsp_tag] = 1'b0;
        busy_cnt = '0;
        for (int i = 0; i < NTAGS; i++) begin
            busy_cnt = busy_cnt + {{TAG_W{1'b0}}, busy_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            next_tag      <= '0;
            busy          <= '0;
            outstanding_q <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (accept) begin
                fifo_mem[wr_ptr[PTR_W-1:0]] <= '{tag: next_tag, addr: bus.req_addr,
                                                 data: bus.req_data, wen: bus.req_wen};
                wr_ptr   <= wr_ptr + PTR_ONE;
                next_tag <= next_tag + TAG_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            busy          <= busy_nxt;
            outstanding_q <= busy_cnt;
        end
    end

`ifdef MEM_PORTQ_ERR_CHECK_EN
    logic [6:0] wd_cnt;
    logic       stall;
    logic       err_q;

    assign stall = bus.req_valid && bus.req_wen && !bus.req_ready && full;

    // wd_cnt counts earlier consecutive stall cycles, so >=64 means this is the 65th.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (!stall)                wd_cnt <= '0;
            else if (wd_cnt != 7'h7F)  wd_cnt <= wd_cnt + 7'd1;
            if ((bus.rsp_valid && !busy[bus.rsp_tag]) || (stall && wd_cnt >= 7'd64))
                err_q <= 1'b1;
        end
    end

    assign bus.err_sticky = err_q;
`else
    assign bus.err_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_request_queue.sv
// Scoreboard bench: stimulus queues expected issue entries, an independent monitor checks every cluster pop.
module tb_mem_port_request_queue;
    logic clk;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    typedef struct packed {
        logic [1:0]  tag;
        logic [11:0] addr;
        logic [15:0] data;
        logic        wen;
    } ent_t;

    ent_t exp_q[$];

    mem_port_request_queue_if #(.ADDR_W(12), .DATA_W(16), .TAG_W(2)) bus ();

    mem_port_request_queue #(.DEPTH(4), .ADDR_W(12), .DATA_W(16), .TAG_W(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the cluster consumes the head, it must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset_n && bus.mem_valid && !bus.freeze_inputs) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL issue_unexpected: got addr 0x%0h expected nothing", bus.mem_addr);
            end else begin
                ent_t e;
                ent_t a;
                e = exp_q.pop_front();
                a = '{tag: bus.mem_req_tag, addr: bus.mem_addr, data: bus.mem_data, wen: bus.mem_wen};
                if (a !== e) begin
                    bad++;
                    $display("FAIL issue_entry: got tag=%0d addr=0x%0h data=0x%0h wen=%0b expected tag=%0d addr=0x%0h data=0x%0h wen=%0b",
                             a.tag, a.addr, a.data, a.wen, e.tag, e.addr, e.data, e.wen);
                end
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wen = 1'b0; bus.req_data = '0;
        bus.freeze_inputs = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_tag = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge, req_valid left high.
    task automatic send(input logic [11:0] a, input logic w, input logic [15:0] d, input logic [1:0] et);
        int n;
        n = 0;
        bus.req_valid = 1'b1; bus.req_addr = a; bus.req_wen = w; bus.req_data = d;
        while (!bus.req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.req_ready) begin
            chk("send_timeout", 32'(bus.req_ready), 32'd1);
        end else begin
            chk("req_tag", 32'(bus.req_tag), 32'(et));
            exp_q.push_back('{tag: et, addr: a, data: d, wen: w});
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
    endtask

    task automatic respond(input logic [1:0] t);
        bus.rsp_valid = 1'b1; bus.rsp_tag = t;
        @(posedge clk); #1;
        bus.rsp_valid = 1'b0;
    endtask

    initial begin
        int   sent;
        int   cyc;
        int   frz_left;
        logic acc;
        logic [1:0] mtag;

        do_reset();
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_outstanding", 32'(bus.outstanding), 32'd0);
        chk("rst_req_tag", 32'(bus.req_tag), 32'd0);
        chk("rst_err", 32'(bus.err_sticky), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);

        // Three back-to-back reads
        send(12'h010, 1'b0, 16'h0000, 2'd0);
        chk("t1_mem_valid_c1", 32'(bus.mem_valid), 32'd1);
        send(12'h011, 1'b0, 16'h0000, 2'd1);
        send(12'h012, 1'b0, 16'h0000, 2'd2);
        idle();
        chk("t1_outstanding", 32'(bus.outstanding), 32'd3);
        @(posedge clk); #1;
        chk("t1_drained", 32'(bus.mem_valid), 32'd0);
        respond(2'd0); respond(2'd1); respond(2'd2);
        chk("t1_released", 32'(bus.outstanding), 32'd0);

        // All four tags busy, fifth read waits for tag 0 to return
        do_reset();
        send(12'h030, 1'b0, 16'h0000, 2'd0);
        send(12'h031, 1'b0, 16'h0000, 2'd1);
        send(12'h032, 1'b0, 16'h0000, 2'd2);
        send(12'h033, 1'b0, 16'h0000, 2'd3);
        chk("t2_outstanding4", 32'(bus.outstanding), 32'd4);
        bus.req_valid = 1'b1; bus.req_addr = 12'h034; bus.req_wen = 1'b0; bus.req_data = '0;
        chk("t2_ready_busy", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        chk("t2_ready_busy2", 32'(bus.req_ready), 32'd0);
        bus.rsp_valid = 1'b1; bus.rsp_tag = 2'd0;
        chk("t2_ready_same_cycle", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        bus.rsp_valid = 1'b0;
        chk("t2_outstanding3", 32'(bus.outstanding), 32'd3);
        chk("t2_ready_after", 32'(bus.req_ready), 32'd1);
        chk("t2_fifth_tag", 32'(bus.req_tag), 32'd0);
        exp_q.push_back('{tag: 2'd0, addr: 12'h034, data: 16'h0000, wen: 1'b0});
        @(posedge clk); #1;
        idle();
        chk("t2_outstanding4b", 32'(bus.outstanding), 32'd4);
        respond(2'd1); respond(2'd2); respond(2'd3); respond(2'd0);
        chk("t2_released", 32'(bus.outstanding), 32'd0);

        // Freeze with four queued writes (next tag is 1 here)
        bus.freeze_inputs = 1'b1;
        send(12'h100, 1'b1, 16'hA000, 2'd1);
        send(12'h101, 1'b1, 16'hA001, 2'd2);
        send(12'h102, 1'b1, 16'hA002, 2'd3);
        send(12'h103, 1'b1, 16'hA003, 2'd0);
        idle();
        for (int i = 0; i < 10; i++) begin
            chk("t3_full_ready", 32'(bus.req_ready), 32'd0);
            chk("t3_head_addr", 32'(bus.mem_addr), 32'h100);
            @(posedge clk); #1;
        end
        bus.freeze_inputs = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t3_drained_4cyc", 32'(bus.mem_valid), 32'd0);
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Write then read of the same address
        do_reset();
        send(12'h3FF, 1'b1, 16'hBEEF, 2'd0);
        send(12'h3FF, 1'b0, 16'h0000, 2'd1);
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("t4_outstanding1", 32'(bus.outstanding), 32'd1);
            @(posedge clk); #1;
        end
        respond(2'd1);
        chk("t4_released", 32'(bus.outstanding), 32'd0);

        // Reset mid-burst with two reads in flight (next tag is 2 here)
        send(12'h020, 1'b0, 16'h0000, 2'd2);
        send(12'h021, 1'b0, 16'h0000, 2'd3);
        chk("t5_inflight", 32'(bus.outstanding), 32'd2);
        chk("t5_queued", 32'(bus.mem_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("t5_rst_outstanding", 32'(bus.outstanding), 32'd0);
        chk("t5_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("t5_rst_req_tag", 32'(bus.req_tag), 32'd0);
        do_reset();
        respond(2'd1);
        @(posedge clk); #1;
        chk("t5_stale_outstanding", 32'(bus.outstanding), 32'd0);
        chk("t5_stale_ready", 32'(bus.req_ready), 32'd1);
`ifdef MEM_PORTQ_ERR_CHECK_EN
        chk("t5_err_sticky", 32'(bus.err_sticky), 32'd1);
`else
        chk("t5_err_sticky", 32'(bus.err_sticky), 32'd0);
`endif

        // 1000 writes with freeze toggling every 1-3 cycles
        sent = 0; cyc = 0; frz_left = 1; mtag = 2'd0;
        while (sent < 1000 && cyc < 20000) begin
            frz_left = frz_left - 1;
            if (frz_left == 0) begin
                bus.freeze_inputs = !bus.freeze_inputs;
                frz_left = $urandom_range(1, 3);
            end
            if (!bus.req_valid && $urandom_range(0, 3) != 0) begin
                bus.req_valid = 1'b1; bus.req_addr = sent[11:0];
                bus.req_wen = 1'b1; bus.req_data = 16'($urandom);
            end
            acc = bus.req_valid && bus.req_ready;
            if (acc) begin
                chk("rnd_tag", 32'(bus.req_tag), 32'(mtag));
                exp_q.push_back('{tag: mtag, addr: bus.req_addr, data: bus.req_data, wen: 1'b1});
                mtag = mtag + 2'd1;
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) bus.req_valid = 1'b0;
        end
        idle();
        bus.freeze_inputs = 1'b0;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rnd_sent", 32'(sent), 32'd1000);
        chk("rnd_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("rnd_idle", 32'(bus.mem_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
